// File: rtl/ecc_rd_ctrl_pkg.sv
// Shared definitions for the ECC read controller: SEC H-matrix columns,
// syndrome inversion mask, FSM state type and the syndrome helper.
package ecc_rd_ctrl_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 6;
  localparam int unsigned RAW_W = DW + CW;

  localparam logic [CW-1:0] SYN_INV = 6'b010101;

  // H-matrix data columns, index i = data bit i. Check bit j has column 1<<j.
  // All columns are distinct, nonzero and not one-hot.
  localparam logic [DW-1:0][CW-1:0] H_DATA = {
    6'h31, 6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C,  // 31..24
    6'h1A, 6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0C,  // 23..16
    6'h07, 6'h30, 6'h28, 6'h24, 6'h12, 6'h21, 6'h18, 6'h14,  // 15..8
    6'h22, 6'h11, 6'h0B, 6'h0A, 6'h09, 6'h06, 6'h05, 6'h03   // 7..0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DEC,
    ST_RESP
  } state_t;

  // syn = H*raw ^ SYN_INV; zero means a clean codeword
  function automatic logic [CW-1:0] calc_syn(input logic [RAW_W-1:0] raw);
    logic [CW-1:0] s;
    s = raw[RAW_W-1:DW] ^ SYN_INV;
    for (int unsigned i = 0; i < DW; i++) begin
      if (raw[i]) s = s ^ H_DATA[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/ecc_syn_dec.sv
// Combinational SEC decoder: corrects a single data-bit error, reports
// check-bit errors as corrected, flags everything else as uncorrectable.
module ecc_syn_dec
  import ecc_rd_ctrl_pkg::*;
(
  input  logic [RAW_W-1:0] raw,
  output logic [DW-1:0]    data,
  output logic             corr,
  output logic             uncorr
);

  logic [CW-1:0] syn;

  // Syndrome lookup and single-bit correction
  always_comb begin
    syn    = calc_syn(raw);
    data   = raw[DW-1:0];
    corr   = 1'b0;
    uncorr = 1'b0;
    if (syn != '0) begin
      if ($onehot(syn)) begin
        corr = 1'b1;
      end else begin
        uncorr = 1'b1;
        for (int unsigned i = 0; i < DW; i++) begin
          if (syn == H_DATA[i]) begin
            data[i] = ~raw[i];
            corr    = 1'b1;
            uncorr  = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ecc_rd_ctrl.sv
// Two-port round-robin read controller for the 38-bit ECC memory.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> DEC -> RESP.
module ecc_rd_ctrl
  import ecc_rd_ctrl_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic [AW-1:0]    p0_addr,
  input  logic             p1_req,
  input  logic [AW-1:0]    p1_addr,
  output logic             p0_ack,
  output logic             p1_ack,
  output logic [DW-1:0]    rdata,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic             busy,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [RAW_W-1:0] mem_rdata
);

  localparam int unsigned LAT_W = 3;

  state_t             state_q, state_d;
  logic               gnt_q;      // 0 = port0, 1 = port1
  logic               last_q;     // port granted by the previous transaction
  logic [AW-1:0]      addr_q;
  logic [LAT_W-1:0]   lat_q;
  logic [RAW_W-1:0]   raw_q;
  logic [DW-1:0]      rdata_q;
  logic               corr_q, uncorr_q;
  logic [CNT_W-1:0]   corr_cnt_q, uncorr_cnt_q;

  logic               grant_go, grant_id, lat_done;
  logic [DW-1:0]      dec_data;
  logic               dec_corr, dec_uncorr;

  assign lat_done = (lat_q == LAT_W'(MEM_LAT - 1));

  ecc_syn_dec u_dec (
    .raw    (raw_q),
    .data   (dec_data),
    .corr   (dec_corr),
    .uncorr (dec_uncorr)
  );

  // Next-state, arbitration and strobe outputs
  always_comb begin
    state_d   = state_q;
    grant_go  = 1'b0;
    grant_id  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          state_d  = ST_ISSUE;
          grant_go = 1'b1;
          grant_id = (p0_req && p1_req) ? ~last_q : p1_req;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (lat_done) state_d = ST_DEC;
      ST_DEC:   state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    mem_rd_en  = (state_q == ST_ISSUE);
    p0_ack     = (state_q == ST_RESP) && !gnt_q;
    p1_ack     = (state_q == ST_RESP) &&  gnt_q;
    busy       = (state_q != ST_IDLE);
    mem_addr   = addr_q;
    rdata      = rdata_q;
    err_corr   = corr_q;
    err_uncorr = uncorr_q;
    corr_cnt   = corr_cnt_q;
    uncorr_cnt = uncorr_cnt_q;
  end

  // State register, grant capture, latency counter and raw codeword capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      lat_q   <= '0;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_go) begin
        gnt_q  <= grant_id;
        addr_q <= grant_id ? p1_addr : p0_addr;
      end
      if (state_q == ST_ISSUE) lat_q <= '0;
      else if (state_q == ST_WAIT) lat_q <= lat_q + LAT_W'(1);
      if (state_q == ST_WAIT && lat_done) raw_q <= mem_rdata;
      if (state_q == ST_RESP) last_q <= gnt_q;
    end
  end

  // Decoded result registers, held until the next DEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else if (state_q == ST_DEC) begin
      rdata_q  <= dec_data;
      corr_q   <= dec_corr;
      uncorr_q <= dec_uncorr;
    end
  end

  // Saturating error counters; a clear overrides a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (clr_cnt) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (corr_q && corr_cnt_q != '1)
        corr_cnt_q <= corr_cnt_q + CNT_W'(1);
      if (uncorr_q && uncorr_cnt_q != '1)
        uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ecc_rd_ctrl.sv
// Directed bench for ecc_rd_ctrl: vector table of single reads plus
// sequences for round-robin, saturation, dropped request and reset abort.
module tb_ecc_rd_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, clr_cnt;
  logic [7:0]  p0_addr, p1_addr;
  logic        p0_ack, p1_ack, err_corr, err_uncorr, busy, mem_rd_en;
  logic [31:0] rdata;
  logic [7:0]  corr_cnt, uncorr_cnt, mem_addr;
  logic [37:0] mem_rdata;
  logic [37:0] cw_drv;
  logic [7:0]  rd_pipe = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        port;
    logic [7:0]  addr;
    logic [37:0] cw;
    logic [31:0] exp_data;
    logic        exp_corr;
    logic        exp_uncorr;
  } vec_t;

  vec_t vecs[9];

  ecc_rd_ctrl #(.AW(8), .MEM_LAT(LAT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0_req     (p0_req),
    .p0_addr    (p0_addr),
    .p1_req     (p1_req),
    .p1_addr    (p1_addr),
    .p0_ack     (p0_ack),
    .p1_ack     (p1_ack),
    .rdata      (rdata),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .busy       (busy),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Fixed-latency memory: codeword is valid only in the cycle LAT after the strobe
  always @(negedge clk) rd_pipe <= {rd_pipe[6:0], mem_rd_en};
  assign mem_rdata = rd_pipe[LAT] ? cw_drv : 38'h2A_5A5A_A5A5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; issues one read and checks timing and result
  task automatic run_txn(input vec_t v);
    cw_drv = v.cw;
    if (v.port) begin p1_req = 1'b1; p1_addr = v.addr; end
    else        begin p0_req = 1'b1; p0_addr = v.addr; end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("mem_rd_en", 64'(mem_rd_en), 64'(k == 1));
      if (k == 1) check("mem_addr", 64'(mem_addr), 64'(v.addr));
      check("p0_ack", 64'(p0_ack), 64'((k == 5) && !v.port));
      check("p1_ack", 64'(p1_ack), 64'((k == 5) && v.port));
    end
    check("rdata", 64'(rdata), 64'(v.exp_data));
    check("err_corr", 64'(err_corr), 64'(v.exp_corr));
    check("err_uncorr", 64'(err_uncorr), 64'(v.exp_uncorr));
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check("busy_after", 64'(busy), 64'(0));
  endtask

  // Bounded wait for the next p0_ack, observed at a negedge
  task automatic wait_p0_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (p0_ack) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL p0_ack_timeout: got no ack expected ack within 20 cycles");
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{1'b0, 8'h10, {6'h15, 32'h0000_0000}, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h21, {6'h15, 32'h0000_0020}, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h3C, {6'h17, 32'h0000_0000}, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h44, {6'h15, 32'h0001_0080}, 32'h0001_0080, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, {6'h16, 32'h0000_0001}, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h00, {6'h16, 32'h0000_0000}, 32'h0000_0001, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h5A, {6'h15, 32'h8000_0000}, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'hA5, {6'h2A, 32'h0000_0000}, 32'h0000_0000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h7E, {6'h35, 32'h0000_0000}, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0; clr_cnt = 1'b0;
    p0_addr = '0; p1_addr = '0; cw_drv = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_flags", 64'({err_corr, err_uncorr, busy, mem_rd_en, p0_ack, p1_ack}), 64'(0));
    check("rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_txn(vecs[i]);

    check("corr_cnt_tbl", 64'(corr_cnt), 64'(5));
    check("uncorr_cnt_tbl", 64'(uncorr_cnt), 64'(2));
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_corr", 64'(corr_cnt), 64'(0));
    check("clr_uncorr", 64'(uncorr_cnt), 64'(0));

    // Request withdrawn after one cycle still completes with an ack
    cw_drv = {6'h16, 32'h0000_0001};
    p1_req = 1'b1; p1_addr = 8'h33;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      p1_req = 1'b0;
      check("drop_rd_en", 64'(mem_rd_en), 64'(k == 1));
      check("drop_p1_ack", 64'(p1_ack), 64'(k == 5));
    end
    check("drop_rdata", 64'(rdata), 64'(32'h1));
    @(negedge clk);
    check("drop_busy", 64'(busy), 64'(0));

    // Reset while waiting on memory aborts with no ack
    cw_drv = {6'h15, 32'h0000_0020};
    p0_req = 1'b1; p0_addr = 8'h44;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", 64'(busy), 64'(1));
    rst = 1'b1; p0_req = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    #1 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("abort_acks", 64'({p0_ack, p1_ack, mem_rd_en, busy}), 64'(0));
    end
    check("abort_rdata", 64'({rdata, err_corr, corr_cnt}), 64'(0));

    // Both ports continuously requesting after reset: p0,p1,p0,p1
    cw_drv = {6'h16, 32'h0000_0001};
    rst = 1'b1;
    #2 rst = 1'b0;
    p0_addr = 8'h11; p1_addr = 8'h22;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      check("rr_p0_ack", 64'(p0_ack), 64'((k % 6 == 5) && ((k / 6) % 2 == 0)));
      check("rr_p1_ack", 64'(p1_ack), 64'((k % 6 == 5) && ((k / 6) % 2 == 1)));
      if (k % 6 == 1)
        check("rr_mem_addr", 64'(mem_addr), 64'(((k / 6) % 2 == 0) ? 8'h11 : 8'h22));
      if (k % 6 == 5) check("rr_rdata", 64'(rdata), 64'(32'h1));
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    check("rr_busy", 64'(busy), 64'(0));

    // Correctable-error counter saturates, then clear wins over increment
    rst = 1'b1;
    #2 rst = 1'b0;
    cw_drv = {6'h15, 32'h0000_0020};
    p0_addr = 8'h01;
    p0_req = 1'b1;
    ok = 1'b1;
    for (int n = 0; n < 255 && ok; n++) wait_p0_ack(ok);
    @(negedge clk);
    check("sat_ff", 64'(corr_cnt), 64'(8'hFF));
    wait_p0_ack(ok);
    @(negedge clk);
    check("sat_hold", 64'(corr_cnt), 64'(8'hFF));
    wait_p0_ack(ok);
    clr_cnt = 1'b1;
    p0_req = 1'b0;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("sat_clr", 64'(corr_cnt), 64'(0));
    check("sat_uncorr", 64'(uncorr_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
